// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST controller slice.
package bist_pkg;

   localparam int unsigned RoundIdxW = 4;

   typedef enum logic [2:0] {
      StIdle,
      StInit,
      StRun,
      StFin,
      StDone
   } bist_state_e;

endpackage

// File: rtl/bist_controller_p_if.sv
// Control/status bundle between the BIST controller and its test datapath.
interface bist_controller_p_if
   import bist_pkg::*;
#(
   parameter int unsigned CNT_W = 8
);

   logic                 start;
   logic                 abort;
   logic                 sig_ok;
   logic                 init;
   logic                 running;
   logic                 toggle;
   logic                 finish;
   logic                 bist_end;
   logic                 pass;
   logic                 busy;
   logic [CNT_W-1:0]     pat_cnt;
   logic [RoundIdxW-1:0] round_idx;

   modport master (
      output start, abort, sig_ok,
      input  init, running, toggle, finish, bist_end, pass, busy, pat_cnt, round_idx
   );

   modport slave (
      input  start, abort, sig_ok,
      output init, running, toggle, finish, bist_end, pass, busy, pat_cnt, round_idx
   );

endinterface

// File: rtl/bist_counter.sv
// Loadable down-counter; tc flags a zero count and the count holds there.
module bist_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         tc
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign cnt = cnt_q;
   assign tc  = (cnt_q == '0);

endmodule

// File: rtl/bist_controller_p.sv
// BIST sequencer: rounds of INIT -> RUN -> FIN, verdict accumulated from sig_ok.
module bist_controller_p
   import bist_pkg::*;
#(
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned N_PAT    = 16,
   parameter int unsigned N_ROUNDS = 2,
   parameter int unsigned INIT_CYC = 2
) (
   input logic                clk,
   input logic                reset_n,
   bist_controller_p_if.slave bus
);

   // Counter must also hold INIT_CYC-1 (up to 14), so never narrower than 4 bits.
   localparam int unsigned CntW = (CNT_W > RoundIdxW) ? CNT_W : RoundIdxW;
   localparam logic [CntW-1:0]      InitLoad  = CntW'(INIT_CYC - 1);
   localparam logic [CntW-1:0]      RunLoad   = CntW'(N_PAT - 1);
   localparam logic [RoundIdxW-1:0] LastRound = RoundIdxW'(N_ROUNDS - 1);

   bist_state_e          state_q, state_d;
   logic [RoundIdxW-1:0] round_q, round_d;
   logic                 toggle_q, toggle_d;
   logic                 pass_q, pass_d;

   logic            cnt_load;
   logic [CntW-1:0] cnt_val;
   logic            cnt_en;
   logic [CntW-1:0] cnt;
   logic            cnt_tc;
   logic [CntW-1:0] pat_full;

   bist_counter #(
      .W (CntW)
   ) u_counter (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (cnt_load),
      .load_val (cnt_val),
      .en       (cnt_en),
      .cnt      (cnt),
      .tc       (cnt_tc)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         round_q  <= '0;
         toggle_q <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         round_q  <= round_d;
         toggle_q <= toggle_d;
         pass_q   <= pass_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      round_d  = round_q;
      toggle_d = toggle_q;
      pass_d   = pass_q;
      cnt_load = 1'b0;
      cnt_val  = InitLoad;
      cnt_en   = 1'b0;

      case (state_q)
         StIdle, StDone: begin
            // abort is ignored here; start alone decides
            if (bus.start) begin
               state_d  = StInit;
               round_d  = '0;
               toggle_d = 1'b0;
               pass_d   = 1'b1;
               cnt_load = 1'b1;
               cnt_val  = InitLoad;
            end
         end
         StInit: begin
            if (bus.abort) begin
               state_d = StDone;
               pass_d  = 1'b0;
            end else if (cnt_tc) begin
               state_d  = StRun;
               cnt_load = 1'b1;
               cnt_val  = RunLoad;
            end else begin
               cnt_en = 1'b1;
            end
         end
         StRun: begin
            if (bus.abort) begin
               state_d = StDone;
               pass_d  = 1'b0;
            end else if (cnt_tc) begin
               state_d = StFin;
            end else begin
               cnt_en = 1'b1;
            end
         end
         StFin: begin
            pass_d = pass_q & bus.sig_ok;
            if (bus.abort) begin
               state_d = StDone;
               pass_d  = 1'b0;
            end else if (round_q == LastRound) begin
               state_d = StDone;
            end else begin
               state_d  = StInit;
               round_d  = round_q + 1'b1;
               toggle_d = ~toggle_q;
               cnt_load = 1'b1;
               cnt_val  = InitLoad;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // RUN counts down internally; present it as an up-count.
   assign pat_full = RunLoad - cnt;

   assign bus.init      = (state_q == StInit);
   assign bus.running   = (state_q == StRun);
   assign bus.finish    = (state_q == StFin);
   assign bus.bist_end  = (state_q == StDone);
   assign bus.busy      = (state_q == StInit) || (state_q == StRun) || (state_q == StFin);
   assign bus.toggle    = toggle_q;
   assign bus.pass      = pass_q;
   assign bus.round_idx = round_q;
   assign bus.pat_cnt   = (state_q == StRun) ? pat_full[CNT_W-1:0] : '0;

endmodule

// File: tb/tb_bist_controller_p.sv
// Directed bench for bist_controller_p: per-cycle vector table plus corner sequences.
module tb_bist_controller_p;
   import bist_pkg::*;

   localparam int unsigned CNT_W    = 4;
   localparam int unsigned N_PAT    = 4;
   localparam int unsigned N_ROUNDS = 2;
   localparam int unsigned INIT_CYC = 2;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;

   always #5 clk = ~clk;

   bist_controller_p_if #(.CNT_W(CNT_W)) bus ();

   bist_controller_p #(
      .CNT_W    (CNT_W),
      .N_PAT    (N_PAT),
      .N_ROUNDS (N_ROUNDS),
      .INIT_CYC (INIT_CYC)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic start, abort, sig_ok;
      logic init, running, toggle, finish, bist_end, pass, busy;
      int   pat;
      int   rnd;
   } vec_t;

   vec_t vecs[$];
   vec_t zero;
   int   n_checks = 0;
   int   n_fails  = 0;

   function automatic vec_t mk(input logic st, ab, ok, i, r, tg, f, e, p, b,
                               input int pc, rd);
      vec_t v;
      v.start = st;  v.abort = ab;  v.sig_ok = ok;
      v.init = i;    v.running = r; v.toggle = tg; v.finish = f;
      v.bist_end = e; v.pass = p;   v.busy = b;
      v.pat = pc;    v.rnd = rd;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input vec_t e);
      chk({tag, ".init"},      int'(bus.init),      int'(e.init));
      chk({tag, ".running"},   int'(bus.running),   int'(e.running));
      chk({tag, ".toggle"},    int'(bus.toggle),    int'(e.toggle));
      chk({tag, ".finish"},    int'(bus.finish),    int'(e.finish));
      chk({tag, ".bist_end"},  int'(bus.bist_end),  int'(e.bist_end));
      chk({tag, ".pass"},      int'(bus.pass),      int'(e.pass));
      chk({tag, ".busy"},      int'(bus.busy),      int'(e.busy));
      chk({tag, ".pat_cnt"},   int'(bus.pat_cnt),   e.pat);
      chk({tag, ".round_idx"}, int'(bus.round_idx), e.rnd);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full 2-round test; each entry = inputs before an edge, outputs after it.
   task automatic add_test(input logic ab0, input logic mid, input logic ok1);
      vecs.push_back(mk(1, ab0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0));
      for (int p = 0; p < 4; p++)
         vecs.push_back(mk(mid && (p == 1 || p == 2), 0, 1, 0, 1, 0, 0, 0, 1, 1, p, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 0, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 0, 1, 1, 0, 1));
      for (int p = 0; p < 4; p++)
         vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 1, 1, p, 1));
      vecs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0, ok1, 0, 0, 1, 0, 1, ok1, 0, 0, 1));
      vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, 1, ok1, 0, 0, 1));
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1);
   end

   initial begin
      int n;
      zero = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      bus.start  = 1'b0;
      bus.abort  = 1'b0;
      bus.sig_ok = 1'b1;

      // Reset with start high is ignored.
      #2 reset_n = 1'b0;
      bus.start = 1'b1;
      #1 chk_all("reset_async", zero);
      step();
      step();
      chk_all("reset_held", zero);
      bus.start = 1'b0;
      reset_n   = 1'b1;
      step();
      chk_all("idle", zero);

      add_test(0, 0, 1);
      add_test(0, 0, 0);
      add_test(1, 1, 1);
      foreach (vecs[i]) begin
         bus.start  = vecs[i].start;
         bus.abort  = vecs[i].abort;
         bus.sig_ok = vecs[i].sig_ok;
         step();
         chk_all($sformatf("vec%0d", i), vecs[i]);
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.sig_ok = 1'b1;

      // Abort in RUN of round 1 at pat_cnt 2.
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      n = 0;
      while (!(bus.running && bus.round_idx == 1 && bus.pat_cnt == 2) && n < 40) begin
         step();
         n++;
      end
      chk("abort_run.reach", int'(bus.running && bus.round_idx == 1 && bus.pat_cnt == 2), 1);
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      chk("abort_run.bist_end", int'(bus.bist_end), 1);
      chk("abort_run.pass", int'(bus.pass), 0);
      chk("abort_run.finish", int'(bus.finish), 0);
      chk("abort_run.busy", int'(bus.busy), 0);
      step();
      chk("abort_run.finish_after", int'(bus.finish), 0);
      chk("abort_run.hold", int'(bus.bist_end), 1);

      // Abort coinciding with the final FIN.
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      n = 0;
      while (!(bus.finish && bus.round_idx == 1) && n < 40) begin
         step();
         n++;
      end
      chk("abort_fin.reach", int'(bus.finish && bus.round_idx == 1), 1);
      bus.abort  = 1'b1;
      bus.sig_ok = 1'b1;
      step();
      bus.abort = 1'b0;
      chk("abort_fin.bist_end", int'(bus.bist_end), 1);
      chk("abort_fin.pass", int'(bus.pass), 0);

      // Abort in the first INIT cycle.
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("abort_init.init", int'(bus.init), 1);
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      chk("abort_init.bist_end", int'(bus.bist_end), 1);
      chk("abort_init.pass", int'(bus.pass), 0);

      // Reset mid-RUN with start held, then restart on the first edge after release.
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      n = 0;
      while (!bus.running && n < 20) begin
         step();
         n++;
      end
      chk("rst_run.reach", int'(bus.running), 1);
      bus.start = 1'b1;
      #2 reset_n = 1'b0;
      #1 chk_all("rst_run.async", zero);
      step();
      step();
      chk_all("rst_run.held", zero);
      #2 reset_n = 1'b1;
      step();
      bus.start = 1'b0;
      chk_all("rst_run.restart", mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0));
      n = 0;
      while (!bus.bist_end && n < 40) begin
         step();
         n++;
      end
      chk("rst_run.duration", n, 14);
      chk("rst_run.pass", int'(bus.pass), 1);
      chk("rst_run.toggle", int'(bus.toggle), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/bist_controller_p.md
BIST_CONTROLLER_P -- requirements
Module: bist_controller_p

Interface
REQ-001 Parameter CNT_W, 8, width of pattern counter.
REQ-002 Parameter N_PAT, 16, patterns per round; legal range 1..2^CNT_W.
REQ-003 Parameter N_ROUNDS, 2, rounds per test; legal range 1..16.
REQ-004 Parameter INIT_CYC, 2, init cycles per round; legal range 1..15.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  level sampled each edge; begins a test when sampled high in IDLE or DONE.
REQ-008 abort  in  1  terminates a test in progress; fails it.
REQ-009 sig_ok  in  1  signature-compare result from datapath, sampled in FIN.
REQ-010 init  out  1  high in INIT state.
REQ-011 running  out  1  high in RUN state.
REQ-012 toggle  out  1  pattern-polarity select; flips at each round boundary.
REQ-013 finish  out  1  one-cycle pulse in FIN state (end of each round).
REQ-014 bist_end  out  1  high in DONE state.
REQ-015 pass  out  1  test verdict; valid while bist_end=1.
REQ-016 busy  out  1  high in INIT, RUN, FIN.
REQ-017 pat_cnt  out  CNT_W  current pattern index in RUN, 0 otherwise.
REQ-018 round_idx  out  4  current round index, 0..N_ROUNDS-1.

Function
REQ-019 FSM states SHALL be IDLE, INIT, RUN, FIN, DONE; all outputs registered or decoded from registered state (Moore, no input-to-output comb paths).
REQ-020 IDLE/DONE with start=1 -> INIT next cycle; round_idx=0, toggle=0, pass cleared to 1, pat_cnt=0.
REQ-021 INIT SHALL last exactly INIT_CYC cycles, then -> RUN.
REQ-022 RUN SHALL last exactly N_PAT cycles, pat_cnt = 0,1,..,N_PAT-1 on successive cycles, then -> FIN.
REQ-023 FIN SHALL last one cycle; pass <= pass AND sig_ok.
REQ-024 FIN with round_idx < N_ROUNDS-1 -> INIT; round_idx increments and toggle inverts on that same edge.
REQ-025 FIN with round_idx = N_ROUNDS-1 -> DONE.
REQ-026 Test duration from first INIT cycle to first DONE cycle SHALL be N_ROUNDS*(INIT_CYC+N_PAT+1) cycles.
REQ-027 DONE SHALL hold bist_end=1, pass, toggle, round_idx stable until start sampled high.
REQ-028 start while busy SHALL be ignored (no restart, no counter disturbance).
REQ-029 abort sampled high in INIT, RUN or FIN -> DONE next cycle with pass=0; finish not pulsed.
REQ-030 abort in IDLE or DONE SHALL be ignored; start and abort both high in IDLE/DONE -> start honoured.
REQ-031 abort and a FIN-to-DONE transition in the same cycle -> DONE with pass=0.
REQ-032 pat_cnt SHALL never wrap: N_PAT=2^CNT_W terminates on pat_cnt = 2^CNT_W-1.

Reset
REQ-033 reset_n low SHALL immediately force IDLE and init=running=toggle=finish=bist_end=busy=0, pass=0, pat_cnt=0, round_idx=0, regardless of clock.
REQ-034 Reset mid-test SHALL abandon the test with no finish or bist_end pulse; start high during reset ignored; start honoured on first edge after reset_n release.

Structure
REQ-035 State encoding enum and round-index width constant (4) SHALL live in shared package bist_pkg.
REQ-036 A sub-module bist_counter (loadable down-counter with terminal-count flag, width parameter) SHALL implement INIT and RUN interval timing; the FSM stays in bist_controller_p.

Verification (bench at CNT_W=4, N_PAT=4, N_ROUNDS=2, INIT_CYC=2)
REQ-037 Reset, start 1 cycle, sig_ok=1 -> init 2 cyc, running 4 cyc (pat_cnt 0..3), finish, toggle=1, repeat; bist_end at cycle 14, pass=1.
REQ-038 Same with sig_ok=0 only in round 1 FIN -> bist_end at cycle 14, pass=0.
REQ-039 start re-asserted during RUN of round 0 -> no effect; bist_end still at cycle 14.
REQ-040 abort in RUN round 1 pat_cnt=2 -> bist_end next cycle, pass=0, no second finish.
REQ-041 reset_n low mid-RUN with start high, release, start pulse -> outputs zero during reset; new full 14-cycle test, toggle starts 0.
REQ-042 Back-to-back: start asserted in DONE -> INIT next cycle, pass=1 restored, round_idx=0.
